// File: rtl/fun_sweep_ctrl.sv
// Truth-table sweep controller: drives all 16 input vectors onto dual-rail
// outputs, samples the evaluator after a settle delay per vector, and compares
// the captured table against a golden table latched at scan start.
// truth_table bit i holds eval_out sampled for vector i = {a,b,c,d}.
module fun_sweep_ctrl #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] expected,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        a_not,
   output logic        b_not,
   output logic        c_not,
   output logic        d_not,
   input  logic        eval_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] truth_table,
   output logic        pass,
   output logic [4:0]  fail_cnt,
   output logic [3:0]  first_fail
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned VEC_N = 16;
   localparam int unsigned FC_W  = 5;

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VEC_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [IDX_W-1:0]    rail_n, rail_n_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [VEC_N-1:0]    exp_q, exp_nxt;
   logic                busy_nxt;
   logic                done_nxt;
   logic [VEC_N-1:0]    table_nxt;
   logic                pass_nxt;
   logic [FC_W-1:0]     fail_cnt_nxt;
   logic [IDX_W-1:0]    first_fail_nxt;

   logic                sample_c;
   logic                last_c;
   logic                miss_c;

   // Sample strobe: settle counter expiring on the current vector
   assign sample_c = (state == ST_SETTLE) && (cnt == CNT_W'(1));
   assign last_c   = sample_c && (idx == LAST_IDX);
   assign miss_c   = (eval_out != exp_q[idx]);

   // Rails come straight from the index register and its complement register
   assign a     = idx[3];
   assign b     = idx[2];
   assign c     = idx[1];
   assign d     = idx[0];
   assign a_not = rail_n[3];
   assign b_not = rail_n[2];
   assign c_not = rail_n[1];
   assign d_not = rail_n[0];

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         rail_n      <= '1;
         cnt         <= '0;
         exp_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         truth_table <= '0;
         pass        <= 1'b0;
         fail_cnt    <= '0;
         first_fail  <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         rail_n      <= rail_n_nxt;
         cnt         <= cnt_nxt;
         exp_q       <= exp_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         truth_table <= table_nxt;
         pass        <= pass_nxt;
         fail_cnt    <= fail_cnt_nxt;
         first_fail  <= first_fail_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start) state_nxt = ST_SETTLE;
         ST_SETTLE: if (last_c) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Datapath/output next values: launch, per-vector sample, and completion
   always_comb begin
      idx_nxt        = idx;
      cnt_nxt        = cnt;
      exp_nxt        = exp_q;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      table_nxt      = truth_table;
      pass_nxt       = pass;
      fail_cnt_nxt   = fail_cnt;
      first_fail_nxt = first_fail;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               exp_nxt        = expected;
               idx_nxt        = '0;
               cnt_nxt        = SETTLE_LD;
               busy_nxt       = 1'b1;
               table_nxt      = '0;
               pass_nxt       = 1'b0;
               fail_cnt_nxt   = '0;
               first_fail_nxt = '0;
            end
         end
         ST_SETTLE: begin
            if (sample_c) begin
               table_nxt[idx] = eval_out;
               if (miss_c) begin
                  fail_cnt_nxt = FC_W'(fail_cnt + FC_W'(1));
                  if (fail_cnt == '0) first_fail_nxt = idx;
               end
               if (last_c) begin
                  busy_nxt = 1'b0;
                  done_nxt = 1'b1;
                  pass_nxt = (fail_cnt == '0) && !miss_c;
               end else begin
                  idx_nxt = IDX_W'(idx + IDX_W'(1));
                  cnt_nxt = SETTLE_LD;
               end
            end else begin
               cnt_nxt = CNT_W'(cnt - CNT_W'(1));
            end
         end
         default: ;
      endcase
   end

   // Complement rails track the next index so both rails change on the same edge
   assign rail_n_nxt = ~idx_nxt;

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Bench for fun_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1) with
// table-driven evaluators, a cycle-level reference model, and a done-driven
// scoreboard of final scan results.
module tb_fun_sweep_ctrl;

   typedef struct packed {
      int          e0;
      logic [15:0] ex;
      logic [15:0] f;
   } rec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rst, start, eval_out;
   logic [1:0]  a, b, c, d, an, bn, cn, dn, busy, done, pass;
   logic [15:0] expected [2];
   logic [15:0] func [2];
   logic [15:0] tt [2];
   logic [4:0]  fc [2];
   logic [3:0]  ff [2];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state
   logic        m_act [2];
   logic        rst_seen [2];
   int          m_e0 [2];
   logic [15:0] m_ex [2];
   logic [15:0] m_f [2];
   int          next_ok [2];
   rec_t        sbq [2][$];

   fun_sweep_ctrl #(.SETTLE(2)) dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .expected(expected[0]),
      .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
      .a_not(an[0]), .b_not(bn[0]), .c_not(cn[0]), .d_not(dn[0]),
      .eval_out(eval_out[0]), .busy(busy[0]), .done(done[0]),
      .truth_table(tt[0]), .pass(pass[0]), .fail_cnt(fc[0]), .first_fail(ff[0])
   );

   fun_sweep_ctrl #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .expected(expected[1]),
      .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]),
      .a_not(an[1]), .b_not(bn[1]), .c_not(cn[1]), .d_not(dn[1]),
      .eval_out(eval_out[1]), .busy(busy[1]), .done(done[1]),
      .truth_table(tt[1]), .pass(pass[1]), .fail_cnt(fc[1]), .first_fail(ff[1])
   );

   // Evaluators: combinational lookup of the active truth table on the true rails
   assign eval_out[0] = func[0][{a[0], b[0], c[0], d[0]}];
   assign eval_out[1] = func[1][{a[1], b[1], c[1], d[1]}];

   function automatic int sval(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic logic [15:0] spec_tt();
      logic [15:0] t;
      logic [3:0]  v;
      t = '0;
      for (int k = 0; k < 16; k++) begin
         v = 4'(k);
         t[k] = ~((~v[1] & v[0]) | (v[3] & v[2] & v[0]) | (v[3] & ~v[2] & ~v[1]));
      end
      return t;
   endfunction

   function automatic logic [3:0] lowest(input logic [15:0] m);
      logic [3:0] r;
      r = '0;
      for (int k = 15; k >= 0; k--) if (m[k]) r = 4'(k);
      return r;
   endfunction

   // Expected {busy,done,table,pass,fail_cnt,first_fail,vector} after the current edge
   function automatic logic [31:0] exp_bundle(input int i);
      int          el, n;
      logic [15:0] mask, mis, tbl;
      logic [4:0]  cnt;
      logic [3:0]  vec;
      logic        bz, dn_p, ps;
      if (!m_act[i]) return '0;
      el   = cyc - m_e0[i];
      n    = el / sval(i);
      if (n > 16) n = 16;
      mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 32'd1);
      tbl  = m_f[i] & mask;
      mis  = (m_f[i] ^ m_ex[i]) & mask;
      cnt  = 5'($countones(mis));
      bz   = (n < 16);
      dn_p = (el == 16 * sval(i));
      ps   = !bz && (cnt == 5'd0);
      vec  = bz ? 4'(n) : 4'd15;
      return {bz, dn_p, tbl, ps, cnt, lowest(mis), vec};
   endfunction

   // Reference model: tracks resets and accepted scans at each rising edge
   always @(posedge clk) begin
      rec_t r;
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            rst_seen[i] = 1'b1;
            m_act[i]    = 1'b0;
            sbq[i].delete();
            next_ok[i]  = cyc + 1;
         end else if (rst_seen[i] && start[i] && cyc >= next_ok[i]) begin
            m_act[i]   = 1'b1;
            m_e0[i]    = cyc;
            m_ex[i]    = expected[i];
            m_f[i]     = func[i];
            next_ok[i] = cyc + 16 * sval(i) + 2;
            r.e0 = cyc; r.ex = expected[i]; r.f = func[i];
            sbq[i].push_back(r);
         end
      end
   end

   // Monitor: per-cycle state/rail checks plus scoreboard pop on done
   always @(negedge clk) begin
      logic [31:0] got, want;
      logic [26:0] rg, rw;
      rec_t        r;
      for (int i = 0; i < 2; i++) begin
         if (rst_seen[i]) begin
            n_vec++;
            if ({a[i], b[i], c[i], d[i]} !== ~{an[i], bn[i], cn[i], dn[i]}) begin
               n_err++;
               $display("FAIL rails inst%0d cyc%0d: true=%b not=%b", i, cyc,
                        {a[i], b[i], c[i], d[i]}, {an[i], bn[i], cn[i], dn[i]});
            end
            got  = {busy[i], done[i], tt[i], pass[i], fc[i], ff[i], a[i], b[i], c[i], d[i]};
            want = exp_bundle(i);
            n_vec++;
            if (got !== want) begin
               n_err++;
               $display("FAIL state inst%0d cyc%0d: got busy=%b done=%b tbl=%h pass=%b fc=%0d ff=%0d vec=%h, want busy=%b done=%b tbl=%h pass=%b fc=%0d ff=%0d vec=%h",
                        i, cyc, got[31], got[30], got[29:14], got[13], got[12:8], got[7:4], got[3:0],
                        want[31], want[30], want[29:14], want[13], want[12:8], want[7:4], want[3:0]);
            end
            if (done[i] === 1'b1) begin
               n_vec++;
               if (sbq[i].size() == 0) begin
                  n_err++;
                  $display("FAIL sb inst%0d cyc%0d: done pulse with no scan outstanding", i, cyc);
               end else begin
                  r  = sbq[i].pop_front();
                  rg = {tt[i], pass[i], fc[i], ff[i]};
                  rw = {r.f, (r.f == r.ex), 5'($countones(r.f ^ r.ex)), lowest(r.f ^ r.ex)};
                  if (rg !== rw || cyc != r.e0 + 16 * sval(i)) begin
                     n_err++;
                     $display("FAIL sb inst%0d: got tbl=%h pass=%b fc=%0d ff=%0d at cyc%0d, want tbl=%h pass=%b fc=%0d ff=%0d at cyc%0d",
                              i, rg[26:11], rg[10], rg[9:5], rg[3:0], cyc,
                              rw[26:11], rw[10], rw[9:5], rw[3:0], r.e0 + 16 * sval(i));
                  end
               end
            end
         end
      end
   end

   task automatic do_reset(input int i, input int n);
      rst[i] = 1'b1;
      repeat (n) @(negedge clk);
      rst[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int limit, input int poke);
      int k = 0;
      while (done[i] !== 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
         start[i] = (k == poke);
      end
      start[i] = 1'b0;
      if (done[i] !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout inst%0d cyc%0d: done=%b, want 1 within %0d cycles", i, cyc, done[i], limit);
      end
   endtask

   // One scan; optional start poke mid-scan, or reset (with start) mid-scan
   task automatic run_scan(input int i, input logic [15:0] f, input logic [15:0] ex,
                           input int poke, input int rst_at);
      func[i]     = f;
      expected[i] = ex;
      start[i]    = 1'b1;
      @(negedge clk);
      start[i]    = 1'b0;
      expected[i] = 16'($urandom);
      if (rst_at > 0) begin
         repeat (rst_at - 1) @(negedge clk);
         rst[i]   = 1'b1;
         start[i] = 1'b1;
         @(negedge clk);
         rst[i]   = 1'b0;
         start[i] = 1'b0;
         repeat (3) @(negedge clk);
      end else begin
         wait_done(i, 40, poke);
         @(negedge clk);
      end
   endtask

   // Start held high across two scans
   task automatic run_held(input int i, input logic [15:0] f, input logic [15:0] ex);
      func[i]     = f;
      expected[i] = ex;
      start[i]    = 1'b1;
      wait_done(i, 40, -1);
      start[i] = 1'b1;
      @(negedge clk);
      wait_done(i, 40, 1000);
      start[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_random(input int i, input int n);
      logic [15:0] f, ex;
      for (int k = 0; k < n; k++) begin
         f = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       ex = f;
            1:       ex = f ^ (16'd1 << $urandom_range(0, 15));
            default: ex = 16'($urandom);
         endcase
         run_scan(i, f, ex, -1, 0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   initial begin
      rst = 2'b11;
      start = 2'b00;
      for (int i = 0; i < 2; i++) begin
         expected[i] = '0;
         func[i]     = '0;
         m_act[i]    = 1'b0;
         rst_seen[i] = 1'b0;
         m_e0[i]     = 0;
         m_ex[i]     = '0;
         m_f[i]      = '0;
         next_ok[i]  = 0;
      end
      fork
         begin
            @(negedge clk);
            do_reset(0, 2);
            repeat (3) @(negedge clk);
            run_scan(0, spec_tt(), 16'h5CDD, -1, 0);
            run_scan(0, spec_tt(), 16'h5CD9, -1, 0);
            run_scan(0, spec_tt(), 16'hA322, -1, 0);
            run_scan(0, spec_tt(), 16'h5CDD, 5, 0);
            run_scan(0, spec_tt(), 16'h5CDD, -1, 10);
            run_held(0, spec_tt(), 16'h5CD9);
            run_random(0, 5);
         end
         begin
            @(negedge clk);
            do_reset(1, 1);
            run_scan(1, spec_tt(), 16'h5CDD, -1, 0);
            run_scan(1, spec_tt(), 16'hA322, 3, 0);
            run_random(1, 6);
            run_held(1, 16'($urandom), 16'($urandom));
            run_scan(1, 16'($urandom), 16'($urandom), -1, 7);
            run_random(1, 2);
         end
      join
      repeat (4) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (sbq[i].size() != 0) begin
            n_err++;
            $display("FAIL drain inst%0d: %0d scans outstanding, want 0", i, sbq[i].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish by cyc%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
